// File: rtl/input_debouncer_pkg.sv
// Shared debouncer types: 2-bit FSM state encoding and counter sizing helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package debounce_pkg;

  // Two idle states remember the accepted level. Two wait states count
  // consecutive synchronized samples that disagree with that level.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } dbnc_state_e;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int DEBOUNCE_CYCLES_MIN = 2;
  localparam int DEBOUNCE_CYCLES_MAX = 65535;

  // The counter holds values 0..cycles-1, so clog2(cycles) bits are enough.
  // The floor of 1 keeps the vector legal for degenerate values.
  function automatic int dbnc_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle: raw button in, debounced level and edge pulses out.
// Latency: none (wiring only).
// Backpressure: none; the outputs are free-running status signals.
// Ports: btn_in (raw input), btn_level, btn_rise, btn_fall (debounced outputs).
interface input_debouncer_if;

  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  // The master drives the raw input and observes the results.
  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall
  );

  // The debouncer itself.
  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall
  );

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer that brings an asynchronous input into the clk domain.
// Latency: STAGES cycles from d_i to q_o.
// Backpressure: none; it samples every cycle.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized).
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Button debouncer: synchronize, then accept a new level after DEBOUNCE_CYCLES equal samples.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES - 1 cycles from the first sample to a btn_level change.
// Backpressure: none; the rise/fall pulses last one cycle and are not held.
// Ports: clk, rst_n (async active-low), bus (slave: btn_in -> btn_level/btn_rise/btn_fall).
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input_debouncer_if.slave   bus
);

  localparam int                 CNT_W    = dbnc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              s;
  dbnc_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.btn_in),
    .q_o   (s)
  );

  // Next-state logic. Entering a wait state already counts the first
  // disagreeing sample, so acceptance happens on the sample where the
  // counter sits at DEBOUNCE_CYCLES-1. The counter therefore stops at that
  // value and never wraps. If the input agrees with the old level on that
  // same sample, the first branch aborts the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // FSM state and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The outputs are registered on the same edge as the state change, so the
  // pulses line up with the btn_level transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_input_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  input_debouncer_if bus ();

  input_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model. The raw input reaches the decision point SYNC edges
  // after it is sampled. A run of DEB consecutive samples that differ from
  // the accepted level flips the level and emits one pulse.
  logic m_sync [SYNC];
  int   m_run;
  logic exp_level, exp_rise, exp_fall;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_run     = 0;
    exp_level = 1'b0;
    exp_rise  = 1'b0;
    exp_fall  = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic s;
    s        = m_sync[SYNC-1];
    exp_rise = 1'b0;
    exp_fall = 1'b0;
    if (s != exp_level) begin
      m_run++;
      if (m_run == DEB) begin
        exp_level = s;
        exp_rise  = s;
        exp_fall  = ~s;
        m_run     = 0;
      end
    end else begin
      m_run = 0;
    end
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = b;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  int rises, falls, rise_edge, fall_edge;

  task automatic clr();
    rises     = 0;
    falls     = 0;
    rise_edge = -1;
    fall_edge = -1;
  endtask

  // Drive one input value, let one active edge pass, then check at the
  // falling edge. The argument e is the edge index used for latency checks.
  task automatic step(input logic b, input int e);
    bus.btn_in = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    chk("level", bus.btn_level, exp_level);
    chk("rise", bus.btn_rise, exp_rise);
    chk("fall", bus.btn_fall, exp_fall);
    chk("rise_fall_excl", bus.btn_rise & bus.btn_fall, 1'b0);
    if (bus.btn_rise === 1'b1) begin
      rises++;
      if (rise_edge < 0) rise_edge = e;
    end
    if (bus.btn_fall === 1'b1) begin
      falls++;
      if (fall_edge < 0) fall_edge = e;
    end
  endtask

  initial begin
    logic lvl;
    int   len;
    bus.btn_in = 1'b0;
    model_reset();
    clr();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_level", bus.btn_level, 1'b0);
    chk("rst_rise", bus.btn_rise, 1'b0);
    chk("rst_fall", bus.btn_fall, 1'b0);
    rst_n = 1'b1;

    // Quiet low input
    for (int e = 0; e < 10; e++) step(1'b0, e);
    chk_int("idle_pulses", rises + falls, 0);

    // Clean 0->1 step
    clr();
    for (int e = 0; e < 7; e++) begin
      step(1'b1, e);
      if (e == 5) chk("step_level_at5", bus.btn_level, 1'b1);
      if (e == 6) chk("step_rise_at6", bus.btn_rise, 1'b0);
    end
    chk_int("step_rise_edge", rise_edge, 5);
    chk_int("step_rise_count", rises, 1);

    // Clean 1->0 step
    clr();
    for (int e = 0; e < 8; e++) step(1'b0, e);
    chk_int("fall_edge", fall_edge, 5);
    chk_int("fall_rises", rises, 0);
    chk("fall_level", bus.btn_level, 1'b0);

    // Bounce, then hold high
    clr();
    step(1'b1, 0);
    step(1'b0, 1);
    step(1'b1, 2);
    step(1'b0, 3);
    for (int e = 0; e < 4; e++) step(1'b1, e);
    chk_int("bounce_pulses", rises + falls, 0);
    clr();
    for (int e = 4; e < 8; e++) step(1'b1, e);
    chk_int("bounce_rise_edge", rise_edge, 5);
    chk_int("bounce_rise_count", rises, 1);
    for (int e = 0; e < 8; e++) step(1'b0, e);

    // Glitch of DEB-1 samples is ignored; DEB samples is accepted
    clr();
    for (int e = 0; e < 3; e++) step(1'b1, e);
    for (int e = 0; e < 8; e++) step(1'b0, e);
    chk_int("glitch3_pulses", rises + falls, 0);
    clr();
    for (int e = 0; e < 4; e++) step(1'b1, e);
    for (int e = 0; e < 10; e++) step(1'b0, e);
    chk_int("glitch4_rises", rises, 1);
    chk_int("glitch4_falls", falls, 1);

    // Fast toggling holds the accepted high level
    for (int e = 0; e < 8; e++) step(1'b1, e);
    clr();
    for (int e = 0; e < 40; e++) step((e % 4) < 2 ? 1'b0 : 1'b1, e);
    chk_int("toggle_pulses", rises + falls, 0);
    chk("toggle_level", bus.btn_level, 1'b1);

    // Reset during a rising wait with two samples counted
    for (int e = 0; e < 8; e++) step(1'b0, e);
    for (int e = 0; e < 4; e++) step(1'b1, e);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_level", bus.btn_level, 1'b0);
    chk("midrst_rise", bus.btn_rise, 1'b0);
    chk("midrst_fall", bus.btn_fall, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr();
    for (int e = 0; e < 10; e++) step(1'b1, e);
    chk_int("postrst_rise_edge", rise_edge, 5);
    chk_int("postrst_rise_count", rises, 1);

    // Random runs of random length against the model
    for (int k = 0; k < 150; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) step(lvl, j);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flip-flops (legal range 2..4).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a new level (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous, bouncing input (switch/button).
REQ-006 SHALL have port btn_level  output  1  debounced registered level.
REQ-007 SHALL have port btn_rise  output  1  one-cycle pulse on an accepted 0->1 transition.
REQ-008 SHALL have port btn_fall  output  1  one-cycle pulse on an accepted 1->0 transition.

Function
REQ-009 SHALL pass btn_in through a chain of SYNC_STAGES D flip-flops; the last stage output is called s.
REQ-010 SHALL implement a 4-state FSM: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 IDLE_LOW: s=1 -> WAIT_HIGH with cnt<=1; otherwise stay.
REQ-012 WAIT_HIGH: s=0 -> IDLE_LOW with cnt<=0; s=1 and cnt=DEBOUNCE_CYCLES-1 -> IDLE_HIGH with btn_level<=1 and btn_rise<=1; otherwise cnt<=cnt+1.
REQ-013 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-011/012 with s inverted, cleared btn_level and btn_fall<=1.
REQ-014 cnt width SHALL be clog2(DEBOUNCE_CYCLES) bits; cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-015 Latency: for a clean step on btn_in first sampled at edge 0, btn_level SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-016 btn_rise/btn_fall SHALL be registered, asserted exactly one cycle, coincident with the btn_level change, and never both high.
REQ-017 A bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on any output.
REQ-018 s returning to the old level in the same cycle cnt would reach the limit SHALL abort (return to IDLE state, no pulse).
REQ-019 Continuous toggling faster than DEBOUNCE_CYCLES SHALL hold btn_level at its last accepted value indefinitely.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear all synchronizer flops, cnt, btn_level, btn_rise and btn_fall, and force IDLE_LOW.
REQ-021 Reset asserted mid-WAIT SHALL discard the partial count; no pulse SHALL be emitted on or after release.
REQ-022 After rst_n release with btn_in held 1, the block SHALL perform a normal debounce and emit one btn_rise.

Structure
REQ-023 FSM state encodings (2-bit) SHALL live in shared package/include debounce_pkg for reuse by sibling blocks.
REQ-024 The synchronizer SHALL be a separate sub-module sync_chain, parameterized by SYNC_STAGES, with reset.
REQ-025 Total RTL SHALL be one FSM always block, one output register block and the sync_chain instance.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-026 Reset, btn_in=0 for 10 cycles -> btn_level=0, btn_rise=btn_fall=0 throughout.
REQ-027 Clean step 0->1 first sampled at edge 0 -> btn_level=1 and btn_rise=1 at edge 5 only; btn_rise=0 at edge 6.
REQ-028 Bounce 1,0,1,0 (one cycle each) then hold 1 -> no pulse during bounce; single btn_rise 5 edges after last 0->1.
REQ-029 Glitch high for exactly 3 cycles from level 0 -> no output change; high for 4 cycles -> one btn_rise.
REQ-030 With btn_level=1, step to 0 -> btn_fall at edge 5, btn_level=0; btn_rise never asserted.
REQ-031 rst_n pulsed low during WAIT_HIGH at cnt=2 -> outputs 0 immediately; with btn_in held 1, btn_rise appears 5 edges after release.
